// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the ALU response path:
//                serial packet geometry, response FSM state type, CRC3
//                polynomial and the error-flag bit positions carried in an
//                ALU error packet.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Serial packet: start(0), type, 8 payload bits, stop(1).
    localparam int PKT_BITS  = 11;
    // Data packets preceding the control packet in a normal response.
    localparam int DATA_PKTS = 4;

    // x^3 + x + 1, leading term implicit.
    localparam logic [2:0] CRC3_POLY = 3'b011;

    // Error flags in an error packet are sent twice, as
    // {DATA, CRC, OP, DATA, CRC, OP}; these are the bit positions inside
    // the 6-bit err_flags word.
    localparam int ERR_DATA_BIT   = 5;
    localparam int ERR_CRC_BIT    = 4;
    localparam int ERR_OP_BIT     = 3;
    localparam int ERR_DATA_BIT_R = 2;
    localparam int ERR_CRC_BIT_R  = 1;
    localparam int ERR_OP_BIT_R   = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DECODE = 2'd2
    } resp_state_t;

    // Expected parity bit of an error packet: XOR of a leading 1 and the
    // six error flags.
    function automatic logic err_parity(input logic [5:0] err);
        return ^{1'b1, err};
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_resp_crc3.sv
`default_nettype none
// ============================================================================
//  Module      : alu_resp_crc3
//  Description : Combinational CRC3 (x^3+x+1, initial value 0) over a
//                37-bit word, processed MSB first.
//  Ports       : i_data [36:0] - message bits
//                o_crc  [2:0]  - remainder
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_resp_crc3
    import alu_pkg::*;
(
    input  logic [36:0] i_data,
    output logic [2:0]  o_crc
);

    always_comb begin
        logic [2:0] w_rem;
        logic       w_fb;
        w_rem = 3'b000;
        w_fb  = 1'b0;
        for (int i = 36; i >= 0; i--) begin
            w_fb  = i_data[i] ^ w_rem[2];
            w_rem = {w_rem[1:0], 1'b0} ^ (w_fb ? CRC3_POLY : 3'b000);
        end
        o_crc = w_rem;
    end

endmodule : alu_resp_crc3
`default_nettype wire

// File: rtl/alu_resp_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_resp_deserializer
//  Description : Samples the ALU serial output line and reassembles response
//                frames (4 data packets + control packet, or a single error
//                packet). Decoded fields are presented in parallel with a
//                one-cycle valid pulse; malformed streams raise proto_err.
//  Ports       : clk, rst (sync, active-high), sout (serial in, idles high)
//                result[31:0], flags[3:0], crc[2:0], err_flags[5:0],
//                is_error, valid, proto_err, parity_err
//                crc_err (only when ALU_RESP_CRC_CHECK_EN is defined)
//  Options     : ALU_RESP_CRC_CHECK_EN - adds CRC3 checking of normal frames
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_resp_deserializer
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sout,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic [2:0]  crc,
    output logic [5:0]  err_flags,
    output logic        is_error,
    output logic        valid,
    output logic        proto_err,
`ifdef ALU_RESP_CRC_CHECK_EN
    output logic        crc_err,
`endif
    output logic        parity_err
);

    localparam logic [3:0] c_LAST_BIT  = 4'(PKT_BITS - 1);
    localparam logic [2:0] c_DATA_PKTS = 3'(DATA_PKTS);

    resp_state_t         r_state;
    logic [3:0]          r_bit_cnt;
    logic [PKT_BITS-2:0] r_shift;
    logic [2:0]          r_pkt_cnt;
    // Assembly buffer: bytes are shifted in MSB first so the first data
    // packet ends up in [31:24]. Kept separate from result so the presented
    // word stays stable while the next frame is arriving.
    logic [31:0]         r_data;

    logic [31:0]         r_result;
    logic [3:0]          r_flags;
    logic [2:0]          r_crc;
    logic [5:0]          r_err_flags;
    logic                r_is_error;
    logic                r_valid;
    logic                r_proto_err;
    logic                r_parity_err;

    // Fields of the captured packet (start bit is not stored).
    logic                w_type;
    logic [7:0]          w_payload;
    logic                w_stop;

    assign w_type    = r_shift[PKT_BITS-2];
    assign w_payload = r_shift[PKT_BITS-3:1];
    assign w_stop    = r_shift[0];

`ifdef ALU_RESP_CRC_CHECK_EN
    logic [2:0] w_crc_calc;
    logic       r_crc_err;

    alu_resp_crc3 u_crc3 (
        .i_data (({r_data, 1'b0, w_payload[6:3]})),
        .o_crc  (w_crc_calc)
    );

    assign crc_err = r_crc_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= 4'd0;
            r_shift      <= '0;
            r_pkt_cnt    <= 3'd0;
            r_data       <= 32'd0;
            r_result     <= 32'd0;
            r_flags      <= 4'd0;
            r_crc        <= 3'd0;
            r_err_flags  <= 6'd0;
            r_is_error   <= 1'b0;
            r_valid      <= 1'b0;
            r_proto_err  <= 1'b0;
            r_parity_err <= 1'b0;
`ifdef ALU_RESP_CRC_CHECK_EN
            r_crc_err    <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low every cycle.
            r_valid      <= 1'b0;
            r_proto_err  <= 1'b0;
            r_parity_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!sout) begin
                        r_bit_cnt <= 4'd1;
                        r_state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    r_shift <= {r_shift[PKT_BITS-3:0], sout};
                    if (r_bit_cnt == c_LAST_BIT) begin
                        r_state <= DECODE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end

                DECODE: begin
                    r_state <= IDLE;
                    if (!w_stop) begin
                        r_proto_err <= 1'b1;
                        r_pkt_cnt   <= 3'd0;
                    end else if (!w_type) begin
                        if (r_pkt_cnt < c_DATA_PKTS) begin
                            r_data    <= {r_data[23:0], w_payload};
                            r_pkt_cnt <= r_pkt_cnt + 3'd1;
                        end else begin
                            r_proto_err <= 1'b1;
                            r_pkt_cnt   <= 3'd0;
                        end
                    end else if (!w_payload[7]) begin
                        if (r_pkt_cnt == c_DATA_PKTS) begin
                            r_result   <= r_data;
                            r_flags    <= w_payload[6:3];
                            r_crc      <= w_payload[2:0];
                            r_is_error <= 1'b0;
                            r_valid    <= 1'b1;
`ifdef ALU_RESP_CRC_CHECK_EN
                            r_crc_err  <= (w_payload[2:0] != w_crc_calc);
`endif
                        end else begin
                            r_proto_err <= 1'b1;
                        end
                        r_pkt_cnt <= 3'd0;
                    end else begin
                        if (r_pkt_cnt == 3'd0) begin
                            r_err_flags  <= w_payload[6:1];
                            r_is_error   <= 1'b1;
                            r_parity_err <= (w_payload[0] != err_parity(w_payload[6:1]));
                            r_valid      <= 1'b1;
`ifdef ALU_RESP_CRC_CHECK_EN
                            r_crc_err    <= 1'b0;
`endif
                        end else begin
                            r_proto_err <= 1'b1;
                        end
                        r_pkt_cnt <= 3'd0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign result     = r_result;
    assign flags      = r_flags;
    assign crc        = r_crc;
    assign err_flags  = r_err_flags;
    assign is_error   = r_is_error;
    assign valid      = r_valid;
    assign proto_err  = r_proto_err;
    assign parity_err = r_parity_err;

endmodule : alu_resp_deserializer
`default_nettype wire
